cr16_control_fsm: RTL

Multi-cycle fetch/decode/execute controller for the CR16 core. It sits directly upstream of the datapath and drives every datapath control input. It owns the PC and the instruction register and sequences the shared von Neumann memory port. It consumes the datapath's A/B operand outputs and its status flags.

---
 rtl/cr16_pkg.sv | 68 ++++++
 rtl/cr16_control_fsm_cond_eval.sv | 40 ++++
 rtl/cr16_control_fsm.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cr16_pkg.sv
// Shared types, instruction-field constants and decode helpers for the CR16 control FSM.
package cr16_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        LOAD_WB = 2'd3
    } state_e;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_SUB  = 4'b1001;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_AND  = 4'b0001;
    localparam logic [3:0] EXT_OR   = 4'b0010;
    localparam logic [3:0] EXT_XOR  = 4'b0011;
    localparam logic [3:0] EXT_MOV  = 4'b1101;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_HI = 4'b0100;
    localparam logic [3:0] COND_LS = 4'b0101;
    localparam logic [3:0] COND_GT = 4'b0110;
    localparam logic [3:0] COND_LE = 4'b0111;
    localparam logic [3:0] COND_FS = 4'b1000;
    localparam logic [3:0] COND_FC = 4'b1001;
    localparam logic [3:0] COND_LO = 4'b1010;
    localparam logic [3:0] COND_HS = 4'b1011;
    localparam logic [3:0] COND_LT = 4'b1100;
    localparam logic [3:0] COND_GE = 4'b1101;
    localparam logic [3:0] COND_UC = 4'b1110;

    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    // ALU operations shared by the register form (ext field) and immediate form (op field).
    function automatic logic is_alu_code(input logic [3:0] code);
        case (code)
            EXT_ADD, EXT_SUB, EXT_CMP, EXT_AND,
            EXT_OR, EXT_XOR, EXT_MOV: is_alu_code = 1'b1;
            default:                  is_alu_code = 1'b0;
        endcase
    endfunction

    function automatic logic is_arith(input logic [3:0] code);
        is_arith = (code == EXT_ADD) || (code == EXT_SUB) || (code == EXT_CMP);
    endfunction

    // LUI is executed by the ALU as a MOV of the pre-shifted immediate.
    function automatic logic [3:0] alu_opcode(input logic [3:0] code);
        alu_opcode = (code == OP_LUI) ? EXT_MOV : code;
    endfunction

endpackage

// File: rtl/cr16_control_fsm_cond_eval.sv
// Combinational CR16 branch/jump condition evaluator over the {C,L,F,Z,N} flags.
module cr16_cond_eval
    import cr16_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [4:0] i_flags,
    output logic       o_taken
);

    logic c, l, f, z, n;

    assign c = i_flags[FLAG_C];
    assign l = i_flags[FLAG_L];
    assign f = i_flags[FLAG_F];
    assign z = i_flags[FLAG_Z];
    assign n = i_flags[FLAG_N];

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_EQ: o_taken = z;
            COND_NE: o_taken = !z;
            COND_CS: o_taken = c;
            COND_CC: o_taken = !c;
            COND_HI: o_taken = l;
            COND_LS: o_taken = !l;
            COND_GT: o_taken = n;
            COND_LE: o_taken = !n;
            COND_FS: o_taken = f;
            COND_FC: o_taken = !f;
            COND_LO: o_taken = !z && !l;
            COND_HS: o_taken = z || l;
            COND_LT: o_taken = !z && !n;
            COND_GE: o_taken = z || n;
            COND_UC: o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cr16_control_fsm.sv
// CR16 multi-cycle fetch/decode/execute controller owning PC, IR and the shared memory port.
// Optional memory wait states are enabled by defining CR16_MEM_READY_EN (adds I_MEM_READY).
module cr16_control_fsm
    import cr16_pkg::*;
#(
    parameter int                      P_ADDR_WIDTH = 16,
    parameter logic [P_ADDR_WIDTH-1:0] P_PC_RESET   = '0
) (
    input  logic                    I_CLK,
    input  logic                    I_RESET,
`ifdef CR16_MEM_READY_EN
    input  logic                    I_MEM_READY,
`endif
    input  logic [15:0]             I_MEM_READ_DATA,
    output logic [P_ADDR_WIDTH-1:0] O_MEM_ADDR,
    output logic                    O_MEM_WRITE_ENABLE,
    output logic [15:0]             O_MEM_WRITE_DATA,
    input  logic [15:0]             I_ALU_A,
    input  logic [15:0]             I_ALU_B,
    input  logic [4:0]              I_STATUS_FLAGS,
    output logic                    O_DATAPATH_ENABLE,
    output logic [15:0]             O_REG_WRITE_ENABLE,
    output logic [3:0]              O_REG_A_SELECT,
    output logic [3:0]              O_REG_B_SELECT,
    output logic                    O_IMMEDIATE_SELECT,
    output logic [15:0]             O_IMMEDIATE,
    output logic [3:0]              O_OPCODE,
    output logic [4:0]              O_STATUS_FLAGS,
    output logic                    O_STATUS_FLAGS_SELECT,
    output logic [15:0]             O_REGFILE_DATA,
    output logic                    O_REGFILE_DATA_SELECT,
    output logic [P_ADDR_WIDTH-1:0] O_PC
);

    state_e                  state_q, state_d;
    logic [P_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]             ir_q, ir_d;

    logic                    mem_ready;
    logic                    cond_taken;
    logic [3:0]              op, rd, ext, rs;
    logic [7:0]              imm8;
    logic [15:0]             rd_onehot;
    logic [P_ADDR_WIDTH-1:0] alu_a_addr;
    logic [P_ADDR_WIDTH-1:0] disp_ext;

`ifdef CR16_MEM_READY_EN
    assign mem_ready = I_MEM_READY;
`else
    assign mem_ready = 1'b1;
`endif

    assign op         = ir_q[15:12];
    assign rd         = ir_q[11:8];
    assign ext        = ir_q[7:4];
    assign rs         = ir_q[3:0];
    assign imm8       = ir_q[7:0];
    assign rd_onehot  = 16'd1 << rd;
    assign alu_a_addr = P_ADDR_WIDTH'(I_ALU_A);
    assign disp_ext   = {{(P_ADDR_WIDTH-8){imm8[7]}}, imm8};
    assign O_PC       = pc_q;

    // Bcond and Jcond both carry their condition in IR[11:8].
    cr16_cond_eval u_cond_eval (
        .i_cond  (rd),
        .i_flags (I_STATUS_FLAGS),
        .o_taken (cond_taken)
    );

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q <= FETCH;
            pc_q    <= P_PC_RESET;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        pc_d                  = pc_q;
        ir_d                  = ir_q;
        O_MEM_ADDR            = pc_q;
        O_MEM_WRITE_ENABLE    = 1'b0;
        O_MEM_WRITE_DATA      = '0;
        O_DATAPATH_ENABLE     = 1'b0;
        O_REG_WRITE_ENABLE    = '0;
        O_REG_A_SELECT        = '0;
        O_REG_B_SELECT        = '0;
        O_IMMEDIATE_SELECT    = 1'b0;
        O_IMMEDIATE           = '0;
        O_OPCODE              = '0;
        O_STATUS_FLAGS_SELECT = 1'b0;
        O_REGFILE_DATA        = '0;
        O_REGFILE_DATA_SELECT = 1'b0;

        case (state_q)
            FETCH: begin
                state_d = DECODE;
            end

            DECODE: begin
                if (mem_ready) begin
                    ir_d    = I_MEM_READ_DATA;
                    pc_d    = pc_q + P_ADDR_WIDTH'(1);
                    state_d = EXECUTE;
                end
            end

            EXECUTE: begin
                state_d = FETCH;
                if (op == OP_RTYPE && is_alu_code(ext)) begin
                    O_REG_A_SELECT        = rs;
                    O_REG_B_SELECT        = rd;
                    O_DATAPATH_ENABLE     = 1'b1;
                    O_OPCODE              = alu_opcode(ext);
                    O_REG_WRITE_ENABLE    = (ext == EXT_CMP) ? 16'h0000 : rd_onehot;
                    O_STATUS_FLAGS_SELECT = !is_arith(ext);
                end else if (is_alu_code(op) || op == OP_LUI) begin
                    O_REG_B_SELECT        = rd;
                    O_DATAPATH_ENABLE     = 1'b1;
                    O_IMMEDIATE_SELECT    = 1'b1;
                    O_OPCODE              = alu_opcode(op);
                    O_REG_WRITE_ENABLE    = (op == EXT_CMP) ? 16'h0000 : rd_onehot;
                    O_STATUS_FLAGS_SELECT = !is_arith(op);
                    if (op == OP_LUI)
                        O_IMMEDIATE = {imm8, 8'h00};
                    else if (is_arith(op))
                        O_IMMEDIATE = {{8{imm8[7]}}, imm8};
                    else
                        O_IMMEDIATE = {8'h00, imm8};
                end else if (op == OP_MEM) begin
                    case (ext)
                        EXT_LOAD: begin
                            O_REG_A_SELECT = rs;
                            O_MEM_ADDR     = alu_a_addr;
                            state_d        = LOAD_WB;
                        end
                        EXT_STOR: begin
                            O_REG_A_SELECT     = rs;
                            O_REG_B_SELECT     = rd;
                            O_MEM_ADDR         = alu_a_addr;
                            O_MEM_WRITE_DATA   = I_ALU_B;
                            O_MEM_WRITE_ENABLE = 1'b1;
                            if (!mem_ready)
                                state_d = EXECUTE;
                        end
                        EXT_JCOND: begin
                            O_REG_A_SELECT = rs;
                            if (cond_taken)
                                pc_d = alu_a_addr;
                        end
                        default: ;
                    endcase
                end else if (op == OP_BCOND) begin
                    // PC already points past this instruction, so the displacement is relative to PC+1.
                    if (cond_taken)
                        pc_d = pc_q + disp_ext;
                end
            end

            LOAD_WB: begin
                // Address stays on the bus so read data remains valid across wait states.
                O_REG_A_SELECT = rs;
                O_MEM_ADDR     = alu_a_addr;
                if (mem_ready) begin
                    O_REGFILE_DATA        = I_MEM_READ_DATA;
                    O_REGFILE_DATA_SELECT = 1'b1;
                    O_REG_WRITE_ENABLE    = rd_onehot;
                    O_DATAPATH_ENABLE     = 1'b1;
                    O_STATUS_FLAGS_SELECT = 1'b1;
                    state_d               = FETCH;
                end
            end

            default: state_d = FETCH;
        endcase

        O_STATUS_FLAGS = O_DATAPATH_ENABLE ? I_STATUS_FLAGS : 5'b00000;
    end

endmodule
